mul_seq_bus: RTL
================

Name: mul_seq_bus

Overview:
- Byte-bus multiplier peripheral for the 8051-driven FPGA tester: the CPU loads two WIDTH-bit operands one byte at a time, pulses start, waits on busy/done, then reads back the 2*WIDTH-bit product one byte at a time.
- Generalises the fixed 16x16 combinational multiplier to a parametrised width, with a sequential radix-2 shift-add core, a start/busy/done handshake and a signed/unsigned mode.

Parameters:
- WIDTH, 16, operand width in bits; multiple of 8, range 8..64. NB = WIDTH/8 is a localparam.
- SEL_W, 2, width of the byte selects; must equal clog2(2*NB); an elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- bus_in  input  8  write data byte
- i_sel  input  SEL_W  write byte index: 0..NB-1 = A byte (0 = LSB), NB..2NB-1 = B byte (NB = B LSB)
- i_enable  input  1  write strobe; one byte written per cycle high
- o_sel  input  SEL_W  product byte index 0..2NB-1 (0 = LSB)
- o_enable  input  1  read strobe
- start  input  1  begin multiply; sampled in IDLE only
- signed_mode  input  1  1 = two's-complement operands; sampled with start
- bus_out  output  8  registered read data
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when the product register updates

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n). While rst_n is low at a clock edge, all registers clear: A, B, product P = 0, bus_out = 0x00, busy = 0, done = 0, FSM = IDLE. Reset asserted mid-operation aborts the multiply and leaves P = 0.
- Operand write: on i_enable, the byte selected by i_sel takes bus_in; all other bytes hold. Writes are accepted in any state. A running multiply works on latched copies, so writes during busy affect only the next start.
- Product read: on o_enable, bus_out <= P[8*o_sel +: 8] at the next edge (1-cycle read latency). Otherwise bus_out holds. P holds the last completed result and stays stable during busy.
- Simultaneous i_enable and o_enable are both serviced in the same cycle.
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 latches the operands. In unsigned mode, MA = A and MB = B. In signed mode, MA = |A| and MB = |B|, and neg = A[W-1]^B[W-1]. The accumulator clears, cnt = WIDTH, busy = 1 from the next cycle, and the FSM goes to RUN.
- RUN: each cycle, if MB[0] then acc += MA<<(WIDTH-cnt). Then MB >>= 1 and cnt--. When cnt reaches 1, the FSM goes to FIN after that iteration. This is exactly WIDTH RUN cycles.
- FIN: P <= neg ? -acc : acc (mod 2^(2*WIDTH)). done = 1 for this single cycle, busy = 0, and the FSM returns to IDLE.
- Latency: start sampled at edge 0 gives busy high for edges 1..WIDTH+1. done and the new P are visible after edge WIDTH+1. The earliest next start is accepted at edge WIDTH+2.
- start while in RUN or FIN is ignored; there is no queueing.
- Signed -2^(W-1) has magnitude 2^(W-1), which the W-bit magnitude register represents as unsigned, so the result is exact.
- A or B = 0 still takes the full latency; no early termination.
- An out-of-range select cannot occur because SEL_W is exact.

Optional Feature:
- Macro: MUL_ACC_EN.
- When defined, the block adds input port acc_en (1 bit, sampled with start, latched for the operation). If latched acc_en = 1, FIN does P <= P + signed_result (mod 2^(2*WIDTH)) instead of overwriting P. Writing any byte with i_sel = 2NB-1 while bus_in = 0xFF and start = 1 is not special; P is cleared only by rst_n or by a start with acc_en = 0.
- When undefined, no acc_en port exists and P is always overwritten.

Test Plan:
- WIDTH=16, unsigned: A=0x1234, B=0x5678, start -> busy 17 cycles, done pulse at edge 17; reads of bytes 3..0 give 0x06,0x26,0x00,0x60.
- Sign mode, A=0xFFFF, B=0x0002: signed_mode=1 -> P=0xFFFFFFFE; signed_mode=0 -> P=0x0001FFFE.
- Corners: A=B=0xFFFF unsigned -> P=0xFFFE0001. A=B=0x8000 signed -> P=0x40000000. A=0 -> P=0 after the full latency.
- Handshake: start pulsed again at edges 3 and 17 -> ignored, single done. A rewritten to 0x0001 during busy -> result still uses the old A; a following start gives the new product.
- Reset: rst_n low at edge 8 of a run -> next cycle busy=0, done never pulses, P=0, bus_out=0x00.
- MUL_ACC_EN: 0x1234*0x5678 with acc_en=0, then again with acc_en=1 -> P=0x0C4C00C0. WIDTH=32 regression: 0xFFFFFFFF squared -> P=0xFFFFFFFE00000001, 33-cycle busy.

Source files
------------

// File: rtl/mul_seq_bus.sv
// Byte-bus sequential shift-add multiplier with start/busy/done handshake and signed mode.
// Optional MUL_ACC_EN adds an acc_en input that accumulates results into P instead of overwriting.
module mul_seq_bus #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       bus_in,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_enable,
  input  logic [SEL_W-1:0] o_sel,
  input  logic             o_enable,
  input  logic             start,
  input  logic             signed_mode,
`ifdef MUL_ACC_EN
  input  logic             acc_en,
`endif
  output logic [7:0]       bus_out,
  output logic             busy,
  output logic             done
);

  localparam int NB = WIDTH / 8;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (SEL_W != $clog2(2 * NB)) begin : g_sel_check
    $error("SEL_W must equal clog2(2*WIDTH/8)");
  end
  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_width_check
    $error("WIDTH must be a multiple of 8 in 8..64");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state;
  logic [PW-1:0]   ops;   // {B, A}, so one byte index addresses both operands
  logic [PW-1:0]   p;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   ma;
  logic [WIDTH-1:0] mb;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            acc_keep;

  logic [WIDTH-1:0] op_a, op_b, mag_a, mag_b;
  logic [PW-1:0]    result;
  logic             start_acc;

  always_comb begin
    op_a   = ops[WIDTH-1:0];
    op_b   = ops[PW-1:WIDTH];
    mag_a  = (signed_mode && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b  = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;
    result = neg ? -acc : acc;
`ifdef MUL_ACC_EN
    start_acc = acc_en;
`else
    start_acc = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      ops      <= '0;
      p        <= '0;
      acc      <= '0;
      ma       <= '0;
      mb       <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      acc_keep <= 1'b0;
      bus_out  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_enable) ops[{i_sel, 3'b000} +: 8] <= bus_in;
      if (o_enable) bus_out <= p[{o_sel, 3'b000} +: 8];
      unique case (state)
        StIdle: begin
          if (start) begin
            ma       <= {{WIDTH{1'b0}}, mag_a};
            mb       <= mag_b;
            neg      <= signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_keep <= start_acc;
            acc      <= '0;
            cnt      <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          // ma is pre-shifted each cycle, equivalent to MA << (WIDTH - cnt)
          if (mb[0]) acc <= acc + ma;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= StFin;
        end
        StFin: begin
          p     <= acc_keep ? (p + result) : result;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
